tx_controller: RTL and testbench

Byte-wide UART transmitter that serialises one 8-bit word per request onto a single idle-high line. Frame format is start bit, 8 data bits LSB first, optional parity bit, then one stop bit. The block sits between the host-side byte source and the TX pin, with no FIFO. The source keeps data stable and uses a level request.

---
 rtl/uart_pkg.sv | 15 +
 rtl/tx_controller_if.sv | 13 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/tx_controller.sv | 121 ++++++++++++
 tb/tb_tx_controller.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/tx_controller_if.sv
// Host-side byte handshake between the byte source (master) and tx_controller (slave).
interface tx_controller_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] i_tx_data;
    logic                 i_tx_ready;
    logic                 o_tx_data;
    logic                 o_tx_busy;

    modport master (output i_tx_data, output i_tx_ready, input o_tx_data, input o_tx_busy);
    modport slave  (input i_tx_data, input i_tx_ready, output o_tx_data, output o_tx_busy);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT enabled cycles, cleared at frame start.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign o_tick = i_en && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tx_controller.sv
// Byte-wide UART transmitter: start, 8 data bits LSB first, optional parity, one stop bit.
// Parity bit is compiled in only when TX_PARITY_EN is defined.
module tx_controller
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic            clk,
    input  logic            reset,
    tx_controller_if.slave  tx
);
    generate
        if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
            $error("tx_controller: illegal CLKS_PER_BIT or PARITY_ODD");
        end
    endgenerate

    tx_state_t            r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [2:0]           r_bit_cnt, w_bit_nxt;
    logic                 r_line, w_line_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 w_tick;
`ifdef TX_PARITY_EN
    logic                 r_par, w_par_nxt;
`endif

    // Counter is held at zero while idle, so every frame starts on a fresh bit period.
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .rst_n   (reset),
        .i_clear (r_state == IDLE),
        .i_en    (r_state != IDLE),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_line    <= LINE_IDLE;
            r_busy    <= 1'b0;
`ifdef TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_line    <= w_line_nxt;
            r_busy    <= w_busy_nxt;
`ifdef TX_PARITY_EN
            r_par     <= w_par_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
`ifdef TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            IDLE: begin
                if (tx.i_tx_ready) begin
                    w_state_nxt = START;
                    w_shift_nxt = tx.i_tx_data;
                    w_bit_nxt   = '0;
`ifdef TX_PARITY_EN
                    // Parity is taken from the byte now, since the shift register is consumed.
                    w_par_nxt   = (^tx.i_tx_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            START: if (w_tick) w_state_nxt = DATA;
            DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef TX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end else begin
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                    end
                end
            end
`ifdef TX_PARITY_EN
            PARITY: if (w_tick) w_state_nxt = STOP;
`endif
            STOP: if (w_tick) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // Line and busy are registered from the next state so they change on the same edge.
        w_line_nxt = LINE_IDLE;
        w_busy_nxt = 1'b1;
        case (w_state_nxt)
            START:   w_line_nxt = 1'b0;
            DATA:    w_line_nxt = w_shift_nxt[0];
`ifdef TX_PARITY_EN
            PARITY:  w_line_nxt = w_par_nxt;
`endif
            STOP:    w_line_nxt = LINE_IDLE;
            default: begin
                w_line_nxt = LINE_IDLE;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign tx.o_tx_data = r_line;
    assign tx.o_tx_busy = r_busy;

endmodule

// File: tb/tb_tx_controller.sv
// Directed bench for tx_controller; frame length follows TX_PARITY_EN.
module tb_tx_controller;

`ifdef TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic clk;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    tx_controller_if if1 ();
    tx_controller_if if4 ();

    tx_controller #(.CLKS_PER_BIT(1), .PARITY_ODD(0)) dut1 (.clk(clk), .reset(reset), .tx(if1));
    tx_controller #(.CLKS_PER_BIT(4), .PARITY_ODD(0)) dut4 (.clk(clk), .reset(reset), .tx(if4));

`ifdef TX_PARITY_EN
    tx_controller_if ifp ();
    tx_controller #(.CLKS_PER_BIT(1), .PARITY_ODD(1)) dutp (.clk(clk), .reset(reset), .tx(ifp));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line value for bit slot i of a frame carrying d.
    function automatic logic fbit(input logic [7:0] d, input int i, input logic odd);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (NBITS == 11 && i == 9) return (^d) ^ odd;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        if1.i_tx_data = 8'hF0; if1.i_tx_ready = 1'b1;
        if4.i_tx_data = 8'hA5; if4.i_tx_ready = 1'b1;
`ifdef TX_PARITY_EN
        ifp.i_tx_data = 8'h00; ifp.i_tx_ready = 1'b1;
`endif

        // Reset held with requests pending: nothing may start.
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("rst_line1_%0d", c), if1.o_tx_data, 1'b1);
            chk($sformatf("rst_busy1_%0d", c), if1.o_tx_busy, 1'b0);
            chk($sformatf("rst_line4_%0d", c), if4.o_tx_data, 1'b1);
            chk($sformatf("rst_busy4_%0d", c), if4.o_tx_busy, 1'b0);
        end
        if1.i_tx_ready = 1'b0;
        if4.i_tx_ready = 1'b0;
`ifdef TX_PARITY_EN
        ifp.i_tx_ready = 1'b0;
`endif
        reset = 1'b1;
        tick();
        chk("idle_line_after_rst", if1.o_tx_data, 1'b1);
        chk("idle_busy_after_rst", if1.o_tx_busy, 1'b0);

        // Single F0 frame, one clock per bit.
        if1.i_tx_data = 8'hF0; if1.i_tx_ready = 1'b1;
        for (int i = 0; i < NBITS; i++) begin
            tick();
            if (i == 0) if1.i_tx_ready = 1'b0;
            chk($sformatf("f0_line_%0d", i), if1.o_tx_data, fbit(8'hF0, i, 1'b0));
            chk($sformatf("f0_busy_%0d", i), if1.o_tx_busy, 1'b1);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            chk($sformatf("f0_idle_line_%0d", c), if1.o_tx_data, 1'b1);
            chk($sformatf("f0_idle_busy_%0d", c), if1.o_tx_busy, 1'b0);
        end

        // A5 frame, four clocks per bit.
        if4.i_tx_data = 8'hA5; if4.i_tx_ready = 1'b1;
        for (int c = 0; c < 4 * NBITS; c++) begin
            tick();
            if (c == 0) if4.i_tx_ready = 1'b0;
            chk($sformatf("a5_line_c%0d", c), if4.o_tx_data, fbit(8'hA5, c / 4, 1'b0));
            chk($sformatf("a5_busy_c%0d", c), if4.o_tx_busy, 1'b1);
        end
        tick();
        chk("a5_end_line", if4.o_tx_data, 1'b1);
        chk("a5_end_busy", if4.o_tx_busy, 1'b0);

        // Request held high; data changes mid-frame must not leak in.
        if1.i_tx_data = 8'h55; if1.i_tx_ready = 1'b1;
        tick();
        chk("b2b_first_start", if1.o_tx_data, 1'b0);
        if1.i_tx_data = 8'h0F;
        for (int i = 1; i < NBITS; i++) begin
            tick();
            chk($sformatf("b2b_55_line_%0d", i), if1.o_tx_data, fbit(8'h55, i, 1'b0));
        end
        tick();
        chk("b2b_gap_line", if1.o_tx_data, 1'b1);
        chk("b2b_gap_busy", if1.o_tx_busy, 1'b0);
        tick();
        chk("b2b_second_start", if1.o_tx_data, 1'b0);
        chk("b2b_second_busy", if1.o_tx_busy, 1'b1);
        if1.i_tx_ready = 1'b0;
        for (int i = 1; i < NBITS; i++) begin
            tick();
            chk($sformatf("b2b_0f_line_%0d", i), if1.o_tx_data, fbit(8'h0F, i, 1'b0));
        end
        tick();
        chk("b2b_end_busy", if1.o_tx_busy, 1'b0);

        // Asynchronous reset while data bit 3 (a zero) is on the line.
        if1.i_tx_data = 8'hA5; if1.i_tx_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            tick();
            if (i == 0) if1.i_tx_ready = 1'b0;
            chk($sformatf("abort_line_%0d", i), if1.o_tx_data, fbit(8'hA5, i, 1'b0));
        end
        #2 reset = 1'b0;
        #1;
        chk("abort_async_line", if1.o_tx_data, 1'b1);
        chk("abort_async_busy", if1.o_tx_busy, 1'b0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("abort_idle_line_%0d", c), if1.o_tx_data, 1'b1);
            chk($sformatf("abort_idle_busy_%0d", c), if1.o_tx_busy, 1'b0);
        end

`ifdef TX_PARITY_EN
        // Byte 07: even parity bit 1, odd parity bit 0.
        if1.i_tx_data = 8'h07; if1.i_tx_ready = 1'b1;
        ifp.i_tx_data = 8'h07; ifp.i_tx_ready = 1'b1;
        for (int i = 0; i < NBITS; i++) begin
            tick();
            if (i == 0) begin
                if1.i_tx_ready = 1'b0;
                ifp.i_tx_ready = 1'b0;
            end
            chk($sformatf("par_even_line_%0d", i), if1.o_tx_data, fbit(8'h07, i, 1'b0));
            chk($sformatf("par_odd_line_%0d", i), ifp.o_tx_data, fbit(8'h07, i, 1'b1));
        end
        tick();
        chk("par_even_end_busy", if1.o_tx_busy, 1'b0);
        chk("par_odd_end_busy", ifp.o_tx_busy, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
